// File: rtl/st_pair_splitter_pkg.sv
// st_pair_splitter_pkg: shared constants and helpers for the pair splitter.
// Holds the pointer-width helper and the stats counter width.
package st_pair_splitter_pkg;

   localparam int unsigned STAT_W = 32;

   // Pointer width for a power-of-two FIFO; never narrower than one bit.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/st_sync_fifo.sv
// st_sync_fifo: show-ahead synchronous FIFO with registered storage.
// Ports: clk, rst (async high), push/din, pop, full, empty, count, head.
module st_sync_fifo
   import st_pair_splitter_pkg::*;
#(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW   = ptr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [PW:0]   count,
   output logic [W-1:0]  head
);

   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full  = (cnt_q == FULL_CNT);
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign head  = mem_q[rd_ptr_q];

   // Guard both sides so a full FIFO never overwrites and an
   // empty one never advances past unwritten data.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/st_pair_splitter.sv
// st_pair_splitter: splits packed {B,A} beats into two Avalon-ST sources.
// Ports: clock_clk, reset_reset (async high), asi_in0_* sink,
// aso_out0_* (A) and aso_out1_* (B) sources.
// Optional ST_PAIR_SPLITTER_STATS_EN adds stat_in/out0/out1_cnt outputs.
module st_pair_splitter
   import st_pair_splitter_pkg::*;
#(
   parameter int unsigned N     = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic            clock_clk,
   input  logic            reset_reset,
   input  logic [2*N-1:0]  asi_in0_data,
   input  logic            asi_in0_valid,
   output logic            asi_in0_ready,
   output logic [N-1:0]    aso_out0_data,
   output logic            aso_out0_valid,
   input  logic            aso_out0_ready,
   output logic [N-1:0]    aso_out1_data,
   output logic            aso_out1_valid,
   input  logic            aso_out1_ready
`ifdef ST_PAIR_SPLITTER_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_in_cnt,
   output logic [STAT_W-1:0] stat_out0_cnt,
   output logic [STAT_W-1:0] stat_out1_cnt
`endif
);

   localparam int unsigned PW = ptr_width(DEPTH);

   typedef struct packed {
      logic [N-1:0] b;
      logic [N-1:0] a;
   } pair_t;

   pair_t       pair;
   logic        full0, full1;
   logic        empty0, empty1;
   logic [PW:0] cnt0, cnt1;
   logic        accept, pop0, pop1;
   logic        unused_cnt;

   assign pair = pair_t'(asi_in0_data);

   // Ready depends only on registered FIFO state, so a pair is
   // accepted into both FIFOs together or not at all.
   assign asi_in0_ready = !full0 && !full1;
   assign accept = asi_in0_valid && asi_in0_ready;

   assign aso_out0_valid = !empty0;
   assign aso_out1_valid = !empty1;
   assign pop0 = aso_out0_valid && aso_out0_ready;
   assign pop1 = aso_out1_valid && aso_out1_ready;

   assign unused_cnt = ^{cnt0, cnt1};

   st_sync_fifo #(
      .W     (N),
      .DEPTH (DEPTH)
   ) u_fifo0 (
      .clk   (clock_clk),
      .rst   (reset_reset),
      .push  (accept),
      .din   (pair.a),
      .pop   (pop0),
      .full  (full0),
      .empty (empty0),
      .count (cnt0),
      .head  (aso_out0_data)
   );

   st_sync_fifo #(
      .W     (N),
      .DEPTH (DEPTH)
   ) u_fifo1 (
      .clk   (clock_clk),
      .rst   (reset_reset),
      .push  (accept),
      .din   (pair.b),
      .pop   (pop1),
      .full  (full1),
      .empty (empty1),
      .count (cnt1),
      .head  (aso_out1_data)
   );

`ifdef ST_PAIR_SPLITTER_STATS_EN
   logic [STAT_W-1:0] stat_in_q, stat_in_d;
   logic [STAT_W-1:0] stat_out0_q, stat_out0_d;
   logic [STAT_W-1:0] stat_out1_q, stat_out1_d;

   always_comb begin
      stat_in_d   = stat_in_q + STAT_W'(accept);
      stat_out0_d = stat_out0_q + STAT_W'(pop0);
      stat_out1_d = stat_out1_q + STAT_W'(pop1);
   end

   always_ff @(posedge clock_clk or posedge reset_reset) begin
      if (reset_reset) begin
         stat_in_q   <= '0;
         stat_out0_q <= '0;
         stat_out1_q <= '0;
      end else begin
         stat_in_q   <= stat_in_d;
         stat_out0_q <= stat_out0_d;
         stat_out1_q <= stat_out1_d;
      end
   end

   assign stat_in_cnt   = stat_in_q;
   assign stat_out0_cnt = stat_out0_q;
   assign stat_out1_cnt = stat_out1_q;
`endif

endmodule

// File: tb/tb_st_pair_splitter.sv
// tb_st_pair_splitter: vector table, directed corner sequences and a
// randomized run against a queue-based model of the splitter.
module tb_st_pair_splitter;
   import st_pair_splitter_pkg::*;

   localparam int N     = 32;
   localparam int DEPTH = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [2*N-1:0] in_data = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [N-1:0]   d0, d1;
   logic           v0, v1;
   logic           r0 = 1'b0;
   logic           r1 = 1'b0;
`ifdef ST_PAIR_SPLITTER_STATS_EN
   logic [STAT_W-1:0] s_in, s_o0, s_o1;
`endif

   int checks = 0;
   int errors = 0;

   logic [N-1:0] got0[$];
   logic [N-1:0] got1[$];

   always #5 clk = ~clk;

   st_pair_splitter #(.N(N), .DEPTH(DEPTH)) dut (
      .clock_clk      (clk),
      .reset_reset    (rst),
      .asi_in0_data   (in_data),
      .asi_in0_valid  (in_valid),
      .asi_in0_ready  (in_ready),
      .aso_out0_data  (d0),
      .aso_out0_valid (v0),
      .aso_out0_ready (r0),
      .aso_out1_data  (d1),
      .aso_out1_valid (v1),
      .aso_out1_ready (r1)
`ifdef ST_PAIR_SPLITTER_STATS_EN
      ,
      .stat_in_cnt    (s_in),
      .stat_out0_cnt  (s_o0),
      .stat_out1_cnt  (s_o1)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle: drive at negedge, sample 1ns later, log pops, then edge.
   task automatic step(input logic v, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic rr0,
                       input logic rr1, output logic rdy);
      @(negedge clk);
      in_valid = v;
      in_data  = {b, a};
      r0 = rr0;
      r1 = rr1;
      #1;
      rdy = in_ready;
      if (v0 && rr0) got0.push_back(d0);
      if (v1 && rr1) got1.push_back(d1);
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      got0.delete();
      got1.delete();
   endtask

   task automatic chk_seq(input string name, input int lo, input int hi);
      chk({name, "_n0"}, 64'(got0.size()), 64'(hi - lo + 1));
      chk({name, "_n1"}, 64'(got1.size()), 64'(hi - lo + 1));
      for (int i = 0; i < got0.size() && i <= hi - lo; i++)
         chk({name, "_o0"}, 64'(got0[i]), 64'(lo + i));
      for (int i = 0; i < got1.size() && i <= hi - lo; i++)
         chk({name, "_o1"}, 64'(got1[i]), 64'(lo + i));
   endtask

   typedef struct {
      logic         v;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         rr0;
      logic         rr1;
      logic         e_rdy;
      logic         e_v0;
      logic [N-1:0] e_d0;
      logic         e_v1;
      logic [N-1:0] e_d1;
   } vec_t;

   vec_t vt[7];

   initial begin
      logic rdy;
      logic [N-1:0] q0[$];
      logic [N-1:0] q1[$];
      int n;

      vt[0] = '{1, 32'h0F, 32'hF0, 1, 1, 1, 0, 0, 0, 0};
      vt[1] = '{0, 0, 0, 1, 1, 1, 1, 32'h0F, 1, 32'hF0};
      vt[2] = '{1, 1, 2, 1, 0, 1, 0, 0, 0, 0};
      vt[3] = '{1, 3, 4, 1, 0, 1, 1, 1, 1, 2};
      vt[4] = '{0, 0, 0, 1, 1, 1, 1, 3, 1, 2};
      vt[5] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 4};
      vt[6] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0};

      // Reset state while reset held, then after release while idle.
      #2;
      chk("rst_ready", 64'(in_ready), 1);
      chk("rst_v0", 64'(v0), 0);
      chk("rst_v1", 64'(v1), 0);
      chk("rst_d0", 64'(d0), 0);
      chk("rst_d1", 64'(d1), 0);
      do_reset();
      #1;
      chk("idle_ready", 64'(in_ready), 1);
      chk("idle_v0", 64'(v0), 0);
      chk("idle_d1", 64'(d1), 0);

      // Vector table
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         in_valid = vt[i].v;
         in_data  = {vt[i].b, vt[i].a};
         r0 = vt[i].rr0;
         r1 = vt[i].rr1;
         #1;
         chk($sformatf("vec%0d_rdy", i), 64'(in_ready), 64'(vt[i].e_rdy));
         chk($sformatf("vec%0d_v0", i), 64'(v0), 64'(vt[i].e_v0));
         chk($sformatf("vec%0d_v1", i), 64'(v1), 64'(vt[i].e_v1));
         if (vt[i].e_v0)
            chk($sformatf("vec%0d_d0", i), 64'(d0), 64'(vt[i].e_d0));
         if (vt[i].e_v1)
            chk($sformatf("vec%0d_d1", i), 64'(d1), 64'(vt[i].e_d1));
      end

      // out1 stalled, six beats offered
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         step(1, N'(i), N'(i), 1, 0, rdy);
         chk("bp_fill_rdy", 64'(rdy), 1);
      end
      step(1, 5, 5, 1, 0, rdy);
      chk("bp_full_rdy", 64'(rdy), 0);
      chk("bp_out0_drained", 64'(got0.size()), 4);
      step(1, 5, 5, 1, 1, rdy);
      chk("bp_pop_edge_rdy", 64'(rdy), 0);
      step(1, 5, 5, 1, 1, rdy);
      chk("bp_after_pop_rdy", 64'(rdy), 1);
      n = 0;
      do begin
         step(1, 6, 6, 1, 1, rdy);
         n++;
      end while (!rdy && n < 20);
      chk("bp_beat6_accepted", 64'(rdy), 1);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, rdy);
      chk_seq("bp", 1, 6);

      // Full FIFO0 with pop and offered input in the same cycle
      do_reset();
      for (int i = 11; i <= 14; i++) step(1, N'(i), N'(i), 0, 1, rdy);
      step(1, 15, 15, 1, 1, rdy);
      chk("fullpop_no_accept", 64'(rdy), 0);
      step(1, 15, 15, 1, 1, rdy);
      chk("fullpop_next_accept", 64'(rdy), 1);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, rdy);
      chk_seq("fullpop", 11, 15);

      // Asynchronous reset with three entries queued
      do_reset();
      for (int i = 21; i <= 23; i++) step(1, N'(i), N'(i), 0, 0, rdy);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("pre_arst_v0", 64'(v0), 1);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_ready", 64'(in_ready), 1);
      chk("arst_v0", 64'(v0), 0);
      chk("arst_v1", 64'(v1), 0);
      chk("arst_d0", 64'(d0), 0);
      chk("arst_d1", 64'(d1), 0);
      @(negedge clk);
      rst = 1'b0;
      got0.delete();
      got1.delete();
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, rdy);
      chk("arst_no_old0", 64'(got0.size()), 0);
      chk("arst_no_old1", 64'(got1.size()), 0);

      // Randomized run against a queue model
      do_reset();
      for (int c = 0; c < 400; c++) begin
         logic rv, ra, rb, acc;
         logic [N-1:0] a, b;
         rv = 1'($urandom_range(0, 1));
         ra = ($urandom_range(0, 3) != 0);
         rb = ($urandom_range(0, 3) != 0);
         a = $urandom;
         b = $urandom;
         @(negedge clk);
         in_valid = rv;
         in_data  = {b, a};
         r0 = ra;
         r1 = rb;
         #1;
         acc = rv && q0.size() < DEPTH && q1.size() < DEPTH;
         chk("rnd_rdy", 64'(in_ready),
             64'(q0.size() < DEPTH && q1.size() < DEPTH));
         chk("rnd_v0", 64'(v0), 64'(q0.size() != 0));
         chk("rnd_v1", 64'(v1), 64'(q1.size() != 0));
         if (q0.size() != 0) chk("rnd_d0", 64'(d0), 64'(q0[0]));
         if (q1.size() != 0) chk("rnd_d1", 64'(d1), 64'(q1[0]));
         @(posedge clk);
         if (ra && q0.size() != 0) void'(q0.pop_front());
         if (rb && q1.size() != 0) void'(q1.pop_front());
         if (acc) begin
            q0.push_back(a);
            q1.push_back(b);
         end
      end

`ifdef ST_PAIR_SPLITTER_STATS_EN
      do_reset();
      for (int i = 1; i <= 10; i++) step(1, N'(i), N'(i), 1, 1, rdy);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, rdy);
      #1;
      chk("stat_in", 64'(s_in), 10);
      chk("stat_o0", 64'(s_o0), 10);
      chk("stat_o1", 64'(s_o1), 10);
      @(negedge clk);
      force dut.stat_in_q = 32'hFFFF_FFFF;
      #1;
      release dut.stat_in_q;
      step(1, 7, 7, 1, 1, rdy);
      #1;
      chk("stat_wrap", 64'(s_in), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation ran past its time limit");
      $fatal(1, "timeout");
   end

endmodule
